sram_arbiter: RTL and testbench

- Arbitrates the DE2-115 16-bit asynchronous SRAM (used as the VGA framebuffer) between two requesters: the VGA display fetch port (read-only, latency-critical) and the gesture/draw engine port (write-only).
- Sequences the SRAM control pins, with reads able to issue back-to-back at one per cycle and writes taking a 3-cycle setup/pulse/hold.
- Reads have priority; a starvation guard guarantees forward progress for writes.
- Sits between the VGA pipeline / draw engine and the SRAM pins at the board top.

---
 rtl/sram_arbiter_pkg.sv | 20 ++
 rtl/sram_arbiter_if.sv | 30 +++
 rtl/sram_arbiter.sv | 179 +++++++++++++++++
 tb/tb_sram_arbiter.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arbiter_pkg.sv
// Shared types and defaults for the framebuffer SRAM arbiter.
package sram_arb_pkg;

  localparam int ADDR_W_DEF = 20;
  localparam int DATA_W_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_READ     = 3'd1,
    ST_WR_SETUP = 3'd2,
    ST_WR_PULSE = 3'd3,
    ST_WR_HOLD  = 3'd4
  } sram_state_e;

  // States in which a new read or write may be accepted.
  function automatic logic is_accepting(input sram_state_e s);
    return (s == ST_IDLE) || (s == ST_READ) || (s == ST_WR_HOLD);
  endfunction

endpackage

// File: rtl/sram_arbiter_if.sv
// Requester-side bundle: display read port and draw-engine write port.
interface sram_arbiter_if
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic              rd_valid;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_ready;
  logic [DATA_W-1:0] rd_data;
  logic              rd_dvalid;
  logic              wr_valid;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [1:0]        wr_be;
  logic              wr_ready;

  modport master (
    output rd_valid, rd_addr, wr_valid, wr_addr, wr_data, wr_be,
    input  rd_ready, rd_data, rd_dvalid, wr_ready
  );

  modport slave (
    input  rd_valid, rd_addr, wr_valid, wr_addr, wr_data, wr_be,
    output rd_ready, rd_data, rd_dvalid, wr_ready
  );

endinterface

// File: rtl/sram_arbiter.sv
// Read-priority arbiter for the async framebuffer SRAM with a write starvation guard.
// All SRAM pins are registered; reads pipeline one per cycle, writes take setup/pulse/hold.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int STARVE_LIMIT = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  sram_arbiter_if.slave     req,
  output logic [ADDR_W-1:0] o_SRAM_ADDR,
  output logic              o_SRAM_CE_N,
  output logic              o_SRAM_OE_N,
  output logic              o_SRAM_WE_N,
  output logic              o_SRAM_LB_N,
  output logic              o_SRAM_UB_N,
  output logic [DATA_W-1:0] o_sram_dq_out,
  output logic              o_sram_dq_oe,
  input  logic [DATA_W-1:0] i_sram_dq_in
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

  sram_state_e       state_r, state_next_s;
  logic              active_r;
  logic [CNT_W-1:0]  starve_cnt_r, starve_cnt_next_s;
  logic [ADDR_W-1:0] addr_r, addr_next_s;
  logic [DATA_W-1:0] dq_out_r, dq_out_next_s;
  logic              dq_oe_r, dq_oe_next_s;
  logic              ce_n_r, ce_n_next_s;
  logic              oe_n_r, oe_n_next_s;
  logic              we_n_r, we_n_next_s;
  logic              lb_n_r, lb_n_next_s;
  logic              ub_n_r, ub_n_next_s;
  logic [DATA_W-1:0] rd_data_r;
  logic              rd_dvalid_r;
  logic              accepting_s, force_wr_s;
  logic              rd_ready_s, wr_ready_s, rd_acc_s, wr_acc_s;

  // Arbitration: reads win unless a pending write has waited STARVE_LIMIT reads.
  // active_r keeps both readies low throughout reset.
  always_comb begin
    accepting_s = active_r && is_accepting(state_r);
    force_wr_s  = req.wr_valid && (starve_cnt_r == STARVE_MAX);
    rd_ready_s  = accepting_s && !force_wr_s;
    wr_ready_s  = accepting_s && (force_wr_s || !req.rd_valid);
    rd_acc_s    = req.rd_valid && rd_ready_s;
    wr_acc_s    = req.wr_valid && wr_ready_s;
  end

  // Next state and next SRAM pin values; pins hold unless the state changes them.
  always_comb begin
    state_next_s  = state_r;
    addr_next_s   = addr_r;
    dq_out_next_s = dq_out_r;
    dq_oe_next_s  = dq_oe_r;
    ce_n_next_s   = ce_n_r;
    oe_n_next_s   = oe_n_r;
    we_n_next_s   = we_n_r;
    lb_n_next_s   = lb_n_r;
    ub_n_next_s   = ub_n_r;
    case (state_r)
      ST_IDLE, ST_READ, ST_WR_HOLD: begin
        if (rd_acc_s) begin
          state_next_s = ST_READ;
          addr_next_s  = req.rd_addr;
          dq_oe_next_s = 1'b0;
          ce_n_next_s  = 1'b0;
          oe_n_next_s  = 1'b0;
          we_n_next_s  = 1'b1;
          lb_n_next_s  = 1'b0;
          ub_n_next_s  = 1'b0;
        end else if (wr_acc_s) begin
          // OE_N goes high here, so a preceding read never overlaps the WE pulse.
          state_next_s  = ST_WR_SETUP;
          addr_next_s   = req.wr_addr;
          dq_out_next_s = req.wr_data;
          dq_oe_next_s  = 1'b1;
          ce_n_next_s   = 1'b0;
          oe_n_next_s   = 1'b1;
          we_n_next_s   = 1'b1;
          lb_n_next_s   = !req.wr_be[0];
          ub_n_next_s   = !req.wr_be[1];
        end else begin
          state_next_s = ST_IDLE;
          dq_oe_next_s = 1'b0;
          ce_n_next_s  = 1'b0;
          oe_n_next_s  = 1'b1;
          we_n_next_s  = 1'b1;
          lb_n_next_s  = 1'b1;
          ub_n_next_s  = 1'b1;
        end
      end
      ST_WR_SETUP: begin
        state_next_s = ST_WR_PULSE;
        we_n_next_s  = 1'b0;
      end
      ST_WR_PULSE: begin
        state_next_s = ST_WR_HOLD;
        we_n_next_s  = 1'b1;
      end
      default: begin
        state_next_s = ST_IDLE;
        dq_oe_next_s = 1'b0;
        ce_n_next_s  = 1'b1;
        oe_n_next_s  = 1'b1;
        we_n_next_s  = 1'b1;
        lb_n_next_s  = 1'b1;
        ub_n_next_s  = 1'b1;
      end
    endcase
  end

  // Starvation counter: counts reads taken while a write waits, saturating.
  always_comb begin
    if (!req.wr_valid || wr_acc_s) begin
      starve_cnt_next_s = '0;
    end else if (rd_acc_s && (starve_cnt_r != STARVE_MAX)) begin
      starve_cnt_next_s = starve_cnt_r + CNT_W'(1);
    end else begin
      starve_cnt_next_s = starve_cnt_r;
    end
  end

  // State, pin and read-return registers; reset forces every strobe inactive at once.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r      <= ST_IDLE;
      active_r     <= 1'b0;
      starve_cnt_r <= '0;
      addr_r       <= '0;
      dq_out_r     <= '0;
      dq_oe_r      <= 1'b0;
      ce_n_r       <= 1'b1;
      oe_n_r       <= 1'b1;
      we_n_r       <= 1'b1;
      lb_n_r       <= 1'b1;
      ub_n_r       <= 1'b1;
      rd_data_r    <= '0;
      rd_dvalid_r  <= 1'b0;
    end else begin
      state_r      <= state_next_s;
      active_r     <= 1'b1;
      starve_cnt_r <= starve_cnt_next_s;
      addr_r       <= addr_next_s;
      dq_out_r     <= dq_out_next_s;
      dq_oe_r      <= dq_oe_next_s;
      ce_n_r       <= ce_n_next_s;
      oe_n_r       <= oe_n_next_s;
      we_n_r       <= we_n_next_s;
      lb_n_r       <= lb_n_next_s;
      ub_n_r       <= ub_n_next_s;
      rd_dvalid_r  <= (state_r == ST_READ);
      if (state_r == ST_READ) begin
        rd_data_r <= i_sram_dq_in;
      end else begin
        rd_data_r <= rd_data_r;
      end
    end
  end

  assign req.rd_ready  = rd_ready_s;
  assign req.wr_ready  = wr_ready_s;
  assign req.rd_data   = rd_data_r;
  assign req.rd_dvalid = rd_dvalid_r;

  assign o_SRAM_ADDR   = addr_r;
  assign o_SRAM_CE_N   = ce_n_r;
  assign o_SRAM_OE_N   = oe_n_r;
  assign o_SRAM_WE_N   = we_n_r;
  assign o_SRAM_LB_N   = lb_n_r;
  assign o_SRAM_UB_N   = ub_n_r;
  assign o_sram_dq_out = dq_out_r;
  assign o_sram_dq_oe  = dq_oe_r;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a behavioural byte-lane SRAM model.
module tb_sram_arbiter;

  logic        clk;
  logic        rst_n;
  logic [19:0] sram_addr;
  logic        ce_n, oe_n, we_n, lb_n, ub_n;
  logic [15:0] dq_out;
  logic        dq_oe;
  logic [15:0] dq_in;
  logic [15:0] mem [0:255];

  int errors = 0;
  int checks = 0;
  int overlap_viol = 0;

  sram_arbiter_if bus ();

  sram_arbiter #(.ADDR_W(20), .DATA_W(16), .STARVE_LIMIT(16)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .req           (bus.slave),
    .o_SRAM_ADDR   (sram_addr),
    .o_SRAM_CE_N   (ce_n),
    .o_SRAM_OE_N   (oe_n),
    .o_SRAM_WE_N   (we_n),
    .o_SRAM_LB_N   (lb_n),
    .o_SRAM_UB_N   (ub_n),
    .o_sram_dq_out (dq_out),
    .o_sram_dq_oe  (dq_oe),
    .i_sram_dq_in  (dq_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model: asynchronous read, byte-lane writes while WE_N is low.
  assign dq_in = (!ce_n && !oe_n) ? mem[sram_addr[7:0]] : 16'h0000;

  always @(posedge clk) begin
    if (!ce_n && !we_n && dq_oe) begin
      if (!lb_n) mem[sram_addr[7:0]][7:0]  <= dq_out[7:0];
      if (!ub_n) mem[sram_addr[7:0]][15:8] <= dq_out[15:8];
    end
  end

  // Bus-contention monitor: OE_N must never be low with WE_N low or DQ driven.
  always @(negedge clk) begin
    if (rst_n && !oe_n && (!we_n || dq_oe)) overlap_viol++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] pat(input logic [7:0] a);
    return {a ^ 8'h5C, ~a};
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  logic [7:0] exp_q [$];
  int nrd, wr_at, k, n;
  logic racc, wacc, acc, dv;
  logic [7:0] a;

  task automatic take_dvalid(input string tag);
    if (bus.rd_dvalid) begin
      if (exp_q.size() == 0) begin
        check_val({tag, "_extra_dvalid"}, 32'd1, 32'd0);
      end else begin
        a = exp_q.pop_front();
        check_val({tag, "_data"}, {16'h0, bus.rd_data}, {16'h0, pat(a)});
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    bus.rd_valid = 1'b0; bus.rd_addr = 20'h0;
    bus.wr_valid = 1'b0; bus.wr_addr = 20'h0; bus.wr_data = 16'h0; bus.wr_be = 2'b00;
    for (int i = 0; i < 256; i++) mem[i] = pat(8'(i));
    mem[8'h10] = 16'hBEEF;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("rst_ce_n", {31'h0, ce_n}, 32'd1);
    check_val("rst_oe_n", {31'h0, oe_n}, 32'd1);
    check_val("rst_we_n", {31'h0, we_n}, 32'd1);
    check_val("rst_lb_ub", {30'h0, lb_n, ub_n}, 32'd3);
    check_val("rst_dq_oe", {31'h0, dq_oe}, 32'd0);
    check_val("rst_addr", {12'h0, sram_addr}, 32'd0);
    check_val("rst_ready", {30'h0, bus.rd_ready, bus.wr_ready}, 32'd0);
    check_val("rst_dvalid", {31'h0, bus.rd_dvalid}, 32'd0);
    rst_n = 1'b1;

    // Single read of 0x10.
    @(posedge clk); #1;
    bus.rd_valid = 1'b1; bus.rd_addr = 20'h00010;
    @(negedge clk);
    check_val("rd1_ready", {31'h0, bus.rd_ready}, 32'd1);
    @(posedge clk); #1;
    bus.rd_valid = 1'b0;
    @(negedge clk);
    check_val("rd1_oe_low", {31'h0, oe_n}, 32'd0);
    check_val("rd1_addr", {12'h0, sram_addr}, 32'h10);
    check_val("rd1_early_dvalid", {31'h0, bus.rd_dvalid}, 32'd0);
    @(negedge clk);
    check_val("rd1_dvalid", {31'h0, bus.rd_dvalid}, 32'd1);
    check_val("rd1_data", {16'h0, bus.rd_data}, 32'hBEEF);
    check_val("rd1_oe_one_cycle", {31'h0, oe_n}, 32'd1);
    @(negedge clk);
    check_val("rd1_dvalid_one", {31'h0, bus.rd_dvalid}, 32'd0);

    // Low-byte write to 0x20; initial word is 0x7CDF.
    @(posedge clk); #1;
    bus.wr_valid = 1'b1; bus.wr_addr = 20'h00020; bus.wr_data = 16'h1234; bus.wr_be = 2'b01;
    @(negedge clk);
    check_val("wr1_ready", {31'h0, bus.wr_ready}, 32'd1);
    @(posedge clk); #1;
    bus.wr_valid = 1'b0;
    n = 0; k = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (!we_n) n++;
      if (dq_oe) k++;
      if (c == 1) check_val("wr1_lb_ub", {30'h0, lb_n, ub_n}, 32'b01);
    end
    check_val("wr1_we_cycles", n, 32'd1);
    check_val("wr1_dq_oe_cycles", k, 32'd3);
    check_val("wr1_mem", {16'h0, mem[8'h20]}, 32'h7C34);

    // Starvation: continuous reads from 0x40 with a write to 0x80 pending.
    @(posedge clk); #1;
    bus.rd_valid = 1'b1; bus.rd_addr = 20'h00040;
    bus.wr_valid = 1'b1; bus.wr_addr = 20'h00080; bus.wr_data = 16'h5A5A; bus.wr_be = 2'b11;
    nrd = 0; wr_at = -1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      take_dvalid("starve");
      racc = bus.rd_valid && bus.rd_ready;
      wacc = bus.wr_valid && bus.wr_ready;
      if (racc) begin exp_q.push_back(bus.rd_addr[7:0]); nrd++; end
      if (wacc) wr_at = nrd;
      @(posedge clk); #1;
      if (racc) bus.rd_addr = bus.rd_addr + 20'd1;
      if (wacc) bus.wr_valid = 1'b0;
    end
    bus.rd_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      take_dvalid("starve");
    end
    check_val("starve_wr_after", wr_at, 32'd16);
    check_val("starve_total_rd", nrd, 32'd37);
    check_val("starve_q_empty", exp_q.size(), 32'd0);
    check_val("starve_wr_mem", {16'h0, mem[8'h80]}, 32'h5A5A);

    // Back-to-back reads of 0..7.
    k = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (c < 8) begin bus.rd_valid = 1'b1; bus.rd_addr = 20'(c); end
      else bus.rd_valid = 1'b0;
      @(negedge clk);
      if (c < 8) check_val("b2b_ready", {31'h0, bus.rd_ready}, 32'd1);
      if (bus.rd_dvalid) begin
        check_val("b2b_data", {16'h0, bus.rd_data}, {16'h0, pat(8'(k))});
        check_val("b2b_slot", c, k + 2);
        k++;
      end
    end
    check_val("b2b_count", k, 32'd8);

    // Write 0x30 then read it straight back.
    @(posedge clk); #1;
    bus.wr_valid = 1'b1; bus.wr_addr = 20'h00030; bus.wr_data = 16'hA5A5; bus.wr_be = 2'b11;
    @(negedge clk);
    check_val("wr2_ready", {31'h0, bus.wr_ready}, 32'd1);
    @(posedge clk); #1;
    bus.wr_valid = 1'b0; bus.rd_valid = 1'b1; bus.rd_addr = 20'h00030;
    acc = 1'b0; n = 0;
    while (!acc && n < 8) begin
      @(negedge clk);
      acc = bus.rd_valid && bus.rd_ready;
      @(posedge clk); #1;
      n++;
    end
    check_val("wr2_rd_accept", {31'h0, acc}, 32'd1);
    check_val("wr2_rd_turn", n, 32'd3);
    bus.rd_valid = 1'b0;
    dv = 1'b0; n = 0;
    while (!dv && n < 6) begin
      @(negedge clk);
      if (bus.rd_dvalid) begin
        dv = 1'b1;
        check_val("wr2_rd_data", {16'h0, bus.rd_data}, 32'hA5A5);
      end
      n++;
    end
    check_val("wr2_rd_dvalid", {31'h0, dv}, 32'd1);

    // Reset asserted during the write pulse.
    @(posedge clk); #1;
    bus.wr_valid = 1'b1; bus.wr_addr = 20'h00050; bus.wr_data = 16'h1111; bus.wr_be = 2'b11;
    @(negedge clk);
    check_val("wr3_ready", {31'h0, bus.wr_ready}, 32'd1);
    @(posedge clk); #1;
    bus.wr_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_val("wr3_pulse_we", {31'h0, we_n}, 32'd0);
    #1 rst_n = 1'b0;
    #1;
    check_val("arst_we_n", {31'h0, we_n}, 32'd1);
    check_val("arst_ce_oe", {30'h0, ce_n, oe_n}, 32'd3);
    check_val("arst_lb_ub", {30'h0, lb_n, ub_n}, 32'd3);
    check_val("arst_dq", {15'h0, dq_oe, dq_out}, 32'd0);
    check_val("arst_addr", {12'h0, sram_addr}, 32'd0);
    check_val("arst_ready", {30'h0, bus.rd_ready, bus.wr_ready}, 32'd0);
    check_val("arst_rd", {15'h0, bus.rd_dvalid, bus.rd_data}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    bus.rd_valid = 1'b1; bus.rd_addr = 20'h00005;
    @(negedge clk);
    check_val("post_rst_ready", {31'h0, bus.rd_ready}, 32'd1);
    @(posedge clk); #1;
    bus.rd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_val("post_rst_dvalid", {31'h0, bus.rd_dvalid}, 32'd1);
    check_val("post_rst_data", {16'h0, bus.rd_data}, {16'h0, pat(8'h05)});

    check_val("oe_overlap", overlap_viol, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
